// File: rtl/phy_rx_serial_demux_if.sv
// Bundle of the serial receive lane and its demultiplexed outputs.
// The master side feeds serial bits and observes the outputs; the slave side is the receiver.
interface phy_rx_serial_demux_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 4
);
    logic                       data_in;
    logic [DATA_W-1:0]          par_data;
    logic                       par_valid;
    logic [NUM_CH*DATA_W-1:0]   data_out;
    logic [NUM_CH-1:0]          valid_out;
    logic                       active;

    modport master (
        output data_in,
        input  par_data,
        input  par_valid,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output par_data,
        output par_valid,
        output data_out,
        output valid_out,
        output active
    );
endinterface

// File: rtl/phy_rx_serial_demux.sv
// Serial-to-parallel receiver with comma-based word alignment and a
// round-robin 1xNUM_CH demux. Bits arrive MSB first, one per clk.
// A word is registered on the same edge that samples its last bit.
module phy_rx_serial_demux #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       NUM_CH   = 4,
    parameter logic [DATA_W-1:0] COMMA    = 8'hBC,
    parameter int unsigned       LOCK_CNT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    phy_rx_serial_demux_if.slave  bus
);
    localparam int unsigned BW = $clog2(DATA_W);
    localparam int unsigned FW = $clog2(DATA_W + 1);
    localparam int unsigned CW = $clog2(LOCK_CNT + 1);
    localparam int unsigned SW = $clog2(NUM_CH);

    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [FW-1:0] FILL_MIN  = FW'(DATA_W - 1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(DATA_W);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
    localparam logic [SW-1:0] CH_LAST   = SW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_ALIGN  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t                     state_q,     state_d;
    logic [DATA_W-1:0]          sr_q,        sr_d;
    logic [FW-1:0]              fill_q,      fill_d;
    logic [BW-1:0]              bit_cnt_q,   bit_cnt_d;
    logic [CW-1:0]              comma_cnt_q, comma_cnt_d;
    logic [SW-1:0]              ch_sel_q,    ch_sel_d;
    logic [DATA_W-1:0]          par_data_q,  par_data_d;
    logic                       par_valid_q, par_valid_d;
    logic [NUM_CH*DATA_W-1:0]   data_out_q,  data_out_d;
    logic [NUM_CH-1:0]          valid_out_q, valid_out_d;
    logic                       active_q,    active_d;

    logic                       word_done_s;
    logic                       is_comma_s;
    logic [BW-1:0]              bit_cnt_next_s;

    // Next-state logic: shift register, fill tracking, alignment FSM and demux.
    always_comb begin
        sr_d        = {sr_q[DATA_W-2:0], bus.data_in};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        ch_sel_d    = ch_sel_q;
        par_data_d  = par_data_q;
        par_valid_d = 1'b0;
        data_out_d  = data_out_q;
        valid_out_d = {NUM_CH{1'b0}};
        active_d    = active_q;

        // Fill saturates so that post-reset zeros can never look like a comma.
        if (fill_q == FILL_MAX) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + FW'(1);
        end

        is_comma_s  = (sr_d == COMMA);
        word_done_s = (bit_cnt_q == BIT_LAST);
        if (word_done_s) begin
            bit_cnt_next_s = {BW{1'b0}};
        end else begin
            bit_cnt_next_s = bit_cnt_q + BW'(1);
        end

        case (state_q)
            S_SEARCH: begin
                // Any bit position may start a word; a comma fixes the phase.
                if ((fill_q >= FILL_MIN) && is_comma_s) begin
                    bit_cnt_d   = {BW{1'b0}};
                    comma_cnt_d = CW'(1);
                    if (LOCK_CNT == 1) begin
                        state_d  = S_ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d  = S_ALIGN;
                    end
                end else begin
                    state_d = S_SEARCH;
                end
            end
            S_ALIGN: begin
                bit_cnt_d = bit_cnt_next_s;
                if (word_done_s) begin
                    if (is_comma_s) begin
                        comma_cnt_d = comma_cnt_q + CW'(1);
                        if (comma_cnt_q == LOCK_LAST) begin
                            state_d  = S_ACTIVE;
                            active_d = 1'b1;
                        end else begin
                            state_d  = S_ALIGN;
                        end
                    end else begin
                        // Misaligned or corrupted: drop the count and hunt again.
                        comma_cnt_d = {CW{1'b0}};
                        state_d     = S_SEARCH;
                    end
                end else begin
                    state_d = S_ALIGN;
                end
            end
            S_ACTIVE: begin
                bit_cnt_d = bit_cnt_next_s;
                if (word_done_s) begin
                    if (is_comma_s) begin
                        // Idle symbol restarts the frame on channel 0.
                        ch_sel_d = {SW{1'b0}};
                    end else begin
                        par_data_d  = sr_d;
                        par_valid_d = 1'b1;
                        for (int k = 0; k < int'(NUM_CH); k++) begin
                            if (ch_sel_q == SW'(k)) begin
                                data_out_d[k*DATA_W +: DATA_W] = sr_d;
                                valid_out_d[k]                 = 1'b1;
                            end else begin
                                valid_out_d[k] = 1'b0;
                            end
                        end
                        if (ch_sel_q == CH_LAST) begin
                            ch_sel_d = {SW{1'b0}};
                        end else begin
                            ch_sel_d = ch_sel_q + SW'(1);
                        end
                    end
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            default: begin
                state_d = S_SEARCH;
            end
        endcase
    end

    // State and output registers with synchronous reset dominating all events.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_SEARCH;
            sr_q        <= {DATA_W{1'b0}};
            fill_q      <= {FW{1'b0}};
            bit_cnt_q   <= {BW{1'b0}};
            comma_cnt_q <= {CW{1'b0}};
            ch_sel_q    <= {SW{1'b0}};
            par_data_q  <= {DATA_W{1'b0}};
            par_valid_q <= 1'b0;
            data_out_q  <= {(NUM_CH*DATA_W){1'b0}};
            valid_out_q <= {NUM_CH{1'b0}};
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            ch_sel_q    <= ch_sel_d;
            par_data_q  <= par_data_d;
            par_valid_q <= par_valid_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            active_q    <= active_d;
        end
    end

    assign bus.par_data  = par_data_q;
    assign bus.par_valid = par_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.active    = active_q;

endmodule

// File: doc/phy_rx_serial_demux.md
Name: phy_rx_serial_demux

Overview:
- Next-generation PHY receive datapath: a single-clock, parametrised merge of serial-to-parallel conversion and the 1xN byte demux.
- Accepts one serial bit per clk, MSB first, and locates word boundaries by searching for the COMMA symbol.
- Declares the lane active after LOCK_CNT consecutive aligned commas.
- Then distributes non-comma words round-robin across NUM_CH output channels, each with a per-channel valid.

Parameters:
- DATA_W, 8, word width in bits (>=4).
- NUM_CH, 4, number of demux output channels (>=2).
- COMMA, 8'hBC, alignment/idle symbol (DATA_W bits).
- LOCK_CNT, 4, consecutive aligned commas required to assert active (>=1).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit, sampled every clk, MSB of each word first.
- par_data  output  DATA_W  last assembled word (pre-demux).
- par_valid  output  1  one-clk pulse: par_data holds a new non-comma word while active.
- data_out  output  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- valid_out  output  NUM_CH  bit k pulses one clk when channel k is updated.
- active  output  1  lane locked; forwarding enabled.

Behaviour:
Fixed interface facts:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.

Reset:
- reset high at a rising edge clears all outputs to 0: par_data, par_valid, data_out, valid_out, active.
- Also clears the shift register, fill counter, bit counter, comma counter and ch_sel; state becomes SEARCH.
- Reset dominates every other event, including mid-word and mid-lock.

Shift register:
- sr_next = {sr[DATA_W-2:0], data_in}, updated every clk.
- fill counter saturates at DATA_W. Comma detection in SEARCH requires the fill count to be DATA_W-1 or more, so reset zeros can never match.

FSM:
- SEARCH:
  - Each clk, if sr_next == COMMA: bit_cnt <= 0 and comma_cnt <= 1.
  - If LOCK_CNT == 1, go directly to ACTIVE; otherwise go to ALIGN.
- ALIGN:
  - bit_cnt increments each clk and wraps DATA_W-1 -> 0. A word completes on the clk where bit_cnt == DATA_W-1, and that word is sr_next.
  - Completed word == COMMA: comma_cnt++. When comma_cnt reaches LOCK_CNT -> ACTIVE, with active <= 1 on the same edge.
  - Completed word != COMMA: comma_cnt <= 0, fill counter kept, return to SEARCH. The search resumes on the next clk (bit-slip tolerant).
- ACTIVE:
  - Word boundaries continue from the same bit_cnt; no re-search.
  - Completed word == COMMA: treated as idle, not forwarded. ch_sel <= 0 (frame realign); par_valid and valid_out stay 0.
  - Completed word != COMMA: on the same edge, par_data <= word and par_valid <= 1. data_out[ch_sel] <= word, valid_out[ch_sel] <= 1, and ch_sel <= (ch_sel == NUM_CH-1) ? 0 : ch_sel+1.
  - active stays 1 until reset. There is no lock-loss detection in this generation.

Output timing:
- Latency: the word appears on outputs 1 clk after its last bit is presented on data_in, i.e. registered on the edge that samples the last bit.
- valid pulses are exactly 1 clk wide. Minimum spacing between pulses is DATA_W clks.
- Unselected channels hold their previous data; their valid bits are 0.

Test Plan:
- Lock and demux: reset 2 clks, serial BC,BC,BC,BC,11,22,33,44,55 (DATA_W=8, NUM_CH=4, LOCK_CNT=4).
  -> active rises at the last bit of the 4th BC.
  -> ch0..3 = 11,22,33,44 with one valid pulse each, 8 clks apart.
  -> 55 goes to ch0; par_data follows each word.
- Bit slip: 3 arbitrary bits (101), then the same stream.
  -> identical word outputs and alignment; no valid before active.
- Broken lock: BC,BC,5A,BC,BC,BC,BC,11.
  -> 5A returns the FSM to SEARCH with active still 0.
  -> lock completes after the four later BCs; 11 goes to ch0.
- Idle realign: once active, send 11,22,BC,33.
  -> ch0=11, ch1=22; BC produces no valid; 33 goes to ch0 (not ch2).
- Reset mid-word: assert reset on the 4th bit of 33 while active.
  -> next clk all outputs 0, active 0.
  -> 11 sent after reset without commas produces no valid.
- Parameter variant: DATA_W=8, NUM_CH=2, LOCK_CNT=1, stream BC,A1,B2,C3.
  -> active after the first BC; ch0=A1, ch1=B2, ch0=C3.
